// File: rtl/gpio_peripherals.sv
// Memory-mapped GPIO: synchronised, debounced inputs with sticky edge flags and
// a level interrupt; outputs with atomic set/clear and per-bit pin polarity.
module gpio_peripherals #(
  parameter int                N_IN            = 4,
  parameter int                N_OUT           = 4,
  parameter int                DEBOUNCE_CYCLES = 4,
  parameter logic [N_OUT-1:0]  OUT_RESET       = '0,
  parameter logic [N_OUT-1:0]  OUT_INVERT      = N_OUT'('hC)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       address,
  input  logic [31:0]       input_data,
  input  logic              should_write,
  output logic [31:0]       output_data,
  input  logic [N_IN-1:0]   input_peripherals,
  output logic [N_OUT-1:0]  output_peripherals,
  output logic              irq
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]  sync1, sync2, stable, stable_nx;
  logic [N_IN-1:0]  edge_r, edge_nx, edge_clr;
  logic [N_IN-1:0]  irq_en, rise_en, fall_en;
  logic [N_OUT-1:0] out_r;
  logic [CW-1:0]    cnt [N_IN];
  logic [2:0]       idx;
  logic             unused_bits;

  assign idx         = address[4:2];
  assign unused_bits = ^{address[31:5], address[1:0], input_data};

  // Acceptance of a debounced level and the resulting edge flag update
  always_comb begin
    stable_nx = stable;
    for (int i = 0; i < N_IN; i++) begin
      if (sync2[i] != stable[i] && cnt[i] == CNT_LAST)
        stable_nx[i] = sync2[i];
    end
    edge_clr = (should_write && idx == 3'd4) ? input_data[N_IN-1:0] : '0;
    edge_nx  = (edge_r & ~edge_clr)
             | (stable_nx & ~stable & rise_en)
             | (~stable_nx & stable & fall_en);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      edge_r  <= '0;
      irq_en  <= '0;
      rise_en <= '0;
      fall_en <= '0;
      out_r   <= OUT_RESET;
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      sync1  <= input_peripherals;
      sync2  <= sync1;
      stable <= stable_nx;
      edge_r <= edge_nx;
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] == stable[i] || cnt[i] == CNT_LAST)
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + CW'(1);
      end
      if (should_write) begin
        case (idx)
          3'd0: out_r   <= input_data[N_OUT-1:0];
          3'd1: out_r   <= out_r | input_data[N_OUT-1:0];
          3'd2: out_r   <= out_r & ~input_data[N_OUT-1:0];
          3'd5: irq_en  <= input_data[N_IN-1:0];
          3'd6: rise_en <= input_data[N_IN-1:0];
          3'd7: fall_en <= input_data[N_IN-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    output_data = '0;
    case (idx)
      3'd0: output_data = 32'(out_r);
      3'd3: output_data = 32'(stable);
      3'd4: output_data = 32'(edge_r);
      3'd5: output_data = 32'(irq_en);
      3'd6: output_data = 32'(rise_en);
      3'd7: output_data = 32'(fall_en);
      default: output_data = '0;
    endcase
  end

  assign output_peripherals = out_r ^ OUT_INVERT;
  assign irq                = |(edge_r & irq_en);

endmodule

// File: tb/tb_gpio_peripherals.sv
// Bench for gpio_peripherals (default parameters): expected values queued at
// stimulus time, popped and compared when the DUT output is sampled.
module tb_gpio_peripherals;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        should_write;
  logic [31:0] output_data;
  logic [3:0]  input_peripherals;
  logic [3:0]  output_peripherals;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  gpio_peripherals dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .address            (address),
    .input_data         (input_data),
    .should_write       (should_write),
    .output_data        (output_data),
    .input_peripherals  (input_peripherals),
    .output_peripherals (output_peripherals),
    .irq                (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    address = addr;
    exp_q.push_back(exp);
    #1;
    check(tag, output_data, exp_q.pop_front());
  endtask

  task automatic pins(input string tag, input logic [3:0] exp_pins, input logic exp_irq);
    exp_q.push_back({28'd0, exp_pins});
    exp_q.push_back({31'd0, exp_irq});
    #1;
    check({tag, ".pins"}, {28'd0, output_peripherals}, exp_q.pop_front());
    check({tag, ".irq"}, {31'd0, irq}, exp_q.pop_front());
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    address = addr; input_data = data; should_write = 1'b1;
    @(negedge clock);
    should_write = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; should_write = 1'b1; address = 32'h0;
    input_data = 32'hF; input_peripherals = 4'h0;
    cycles(3);
    rd("rst.out", 32'h00, 32'h0);
    pins("rst", 4'hC, 1'b0);
    for (int i = 1; i < 8; i++) rd($sformatf("rst.reg%0d", i), i * 4, 32'h0);
    should_write = 1'b0; reset_n = 1'b1;

    // output set/clear
    wr(32'h00, 32'h5);
    rd("out.wr", 32'h00, 32'h5);   pins("out.wr", 4'h9, 1'b0);
    wr(32'h04, 32'h2);
    rd("out.set", 32'h00, 32'h7);  pins("out.set", 4'hB, 1'b0);
    wr(32'h08, 32'h4);
    rd("out.clr", 32'h00, 32'h3);  pins("out.clr", 4'hF, 1'b0);
    rd("rd.outset", 32'h04, 32'h0);
    rd("rd.outclr", 32'h08, 32'h0);
    wr(32'h00, 32'hFFFF_FFFF);
    rd("out.width", 32'h00, 32'hF);
    wr(32'h00, 32'h3);

    // debounce: 3-cycle glitch discarded
    @(negedge clock); input_peripherals = 4'h1;
    cycles(3); input_peripherals = 4'h0;
    cycles(8);
    rd("glitch.in", 32'h0C, 32'h0);
    // clean transition accepted exactly 6 edges later
    input_peripherals = 4'h1;
    cycles(5); rd("deb.in5", 32'h0C, 32'h0);
    cycles(1); rd("deb.in6", 32'h0C, 32'h1);
    rd("deb.edge", 32'h10, 32'h0);
    input_peripherals = 4'h2;
    cycles(10);
    rd("deb.pin1", 32'h0C, 32'h2);

    // edge flags and interrupt
    wr(32'h18, 32'h1); wr(32'h1C, 32'h2); wr(32'h14, 32'h3);
    rd("en.rise", 32'h18, 32'h1);
    rd("edge.none", 32'h10, 32'h0); pins("edge.none", 4'hF, 1'b0);
    @(negedge clock); input_peripherals = 4'h3;
    cycles(10); input_peripherals = 4'h2;
    cycles(10);
    rd("edge.rise0", 32'h10, 32'h1); pins("edge.rise0", 4'hF, 1'b1);
    input_peripherals = 4'h0;
    cycles(5); rd("edge.fall1_5", 32'h10, 32'h1);
    cycles(1); rd("edge.fall1_6", 32'h10, 32'h3);
    wr(32'h10, 32'h1);
    rd("w1c.0", 32'h10, 32'h2); pins("w1c.0", 4'hF, 1'b1);
    wr(32'h10, 32'h2);
    rd("w1c.1", 32'h10, 32'h0); pins("w1c.1", 4'hF, 1'b0);

    // W1C collides with a new rising edge on the same channel
    @(negedge clock); input_peripherals = 4'h1;
    cycles(5);
    address = 32'h10; input_data = 32'h1; should_write = 1'b1;
    @(negedge clock); should_write = 1'b0;
    rd("coll.in", 32'h0C, 32'h1);
    rd("coll.edge", 32'h10, 32'h1);

    // address decode
    wr(32'h0C, 32'hF);
    rd("dec.in_wr", 32'h0C, 32'h1);
    wr(32'h13, 32'h1);
    rd("dec.lowbits_w1c", 32'h10, 32'h0);
    wr(32'h03, 32'h6);
    rd("dec.lowbits_out", 32'h03, 32'h6); pins("dec.lowbits", 4'hA, 1'b0);
    wr(32'h18, 32'hFFFF_FFFF);
    rd("dec.width", 32'h1B, 32'hF);

    // reset beats a concurrent write
    @(negedge clock);
    reset_n = 1'b0; address = 32'h14; input_data = 32'hF; should_write = 1'b1;
    @(negedge clock);
    should_write = 1'b0; reset_n = 1'b1;
    rd("rst2.irqen", 32'h14, 32'h0);
    rd("rst2.rise", 32'h18, 32'h0);
    rd("rst2.out", 32'h00, 32'h0);
    pins("rst2", 4'hC, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_peripherals.md
# gpio_peripherals

Parametrised memory-mapped GPIO block on the data-memory bus, the next generation of the fixed 4-in/4-out peripheral port. It provides N_IN synchronised, debounced input channels with per-channel rising/falling edge detection. Edge events latch into sticky write-1-to-clear flags that drive a single level interrupt. N_OUT output channels support atomic set/clear writes and per-bit output polarity.

## Interface
- N_IN, 4: number of input channels, 1..32
- N_OUT, 4: number of output channels, 1..32
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised input must differ from its stable value before acceptance, ≥1
- OUT_RESET, 0: OUT register value after reset, N_OUT bits
- OUT_INVERT, 'hC: per-bit pin inversion mask, N_OUT bits; default is active-low LEDs on channels 2 and 3
- clock  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  reset, synchronous, active-low
- address  input  32  byte address; word index = address[4:2]; address[1:0] ignored
- input_data  input  32  write data
- should_write  input  1  write strobe, sampled at rising edge
- output_data  output  32  combinational read data for the current address
- input_peripherals  input  N_IN  asynchronous pins
- output_peripherals  output  N_OUT  pins = OUT ^ OUT_INVERT
- irq  output  1  level interrupt = |(EDGE & IRQ_EN)

## Operation
- Register map by word index. Bits above channel width read 0 and ignore writes.
  - 0 OUT (RW)
  - 1 OUT_SET (W; reads 0): OUT |= data
  - 2 OUT_CLR (W; reads 0): OUT &= ~data
  - 3 IN (R): debounced stable levels
  - 4 EDGE (R, W1C)
  - 5 IRQ_EN (RW)
  - 6 RISE_EN (RW)
  - 7 FALL_EN (RW)
- Writes to IN are ignored.
- Input path per channel:
  - Two-flop synchroniser (sync1, sync2) feeds the debouncer.
  - Debounce counter, width clog2(DEBOUNCE_CYCLES+1). Cleared whenever sync2 == stable; otherwise increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync2 != stable: stable <= sync2 and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- Edge flags:
  - On the edge where stable goes 0→1 with RISE_EN[i]=1, or 1→0 with FALL_EN[i]=1, EDGE[i] <= 1.
  - A W1C write clears the written 1-bits.
  - Set has priority over a simultaneous clear of the same bit.
  - Changing RISE_EN or FALL_EN never retroactively sets or clears flags.
- Reset (reset_n=0 at a rising edge) clears:
  - sync flops, stable, counters, EDGE, IRQ_EN, RISE_EN, FALL_EN → 0
  - OUT → OUT_RESET
  - Resulting outputs: output_peripherals = OUT_RESET ^ OUT_INVERT, irq = 0
- Reset takes priority over any concurrent write.

## Timing
- Write latency: register updates at the rising edge where should_write=1. output_peripherals and irq reflect the change immediately after that edge (XOR/OR of registers only, no extra stage).
- Read: output_data is combinational from address and current register state. No read side effects.
- Input latency: a clean pin transition is visible in IN after 2 + DEBOUNCE_CYCLES rising edges. The EDGE flag sets on the same edge as IN, and irq rises right after it.
- Pin held through reset deassert: stable reaches pin level after 2 + DEBOUNCE_CYCLES cycles. A flag is produced only if enabled at that time (enables are 0 after reset, so none).
- Back-to-back writes on consecutive cycles are all honoured.
- A W1C write and a new edge on the same channel in the same cycle leave the flag at 1.

## Test plan
- Reset: hold reset_n=0 with should_write=1 to OUT, value 'hF. Expect OUT reads 0, output_peripherals='hC, irq=0, all other registers read 0.
- Set/clear: write OUT='h5, OUT_SET='h2, then OUT_CLR='h4. Expect OUT reads 'h7 then 'h3, and output_peripherals='hB then 'hF, each one edge after its write.
- Debounce (DEBOUNCE_CYCLES=4): pin0 high for 3 cycles then low → IN stays 0, no flag. Pin0 held high → IN[0]=1 exactly 6 edges after the change.
- Edge/IRQ: RISE_EN='h1, FALL_EN='h2, IRQ_EN='h3. Pulse pin0 high, then toggle pin1 1→0. Expect EDGE='h1 then 'h3, irq=1. Write EDGE='h1 → EDGE='h2, irq=1. Write EDGE='h2 → irq=0.
- Collision: schedule a W1C of EDGE[0] on the same edge that stable[0] rises with RISE_EN[0]=1 → EDGE[0]=1.
- Address decode: reads of OUT_SET and OUT_CLR return 0. A write to IN has no effect. An address with address[1:0]='b11 decodes to the same word.
